// File: rtl/workers_cpu_0_mul_sequencer_if.sv
// Handshake bundle for the shared multiplier sequencer: two operand requesters,
// one response channel, the flush strobe and busy status.
interface workers_cpu_0_mul_sequencer_if;
    logic        flush;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        busy;

    modport master (
        output flush, req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_lo, rsp_hi, busy
    );

    modport slave (
        input  flush, req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_lo, rsp_hi, busy
    );
endinterface

// File: rtl/workers_cpu_0_mul_sequencer.sv
// Shares one registered 16x16 multiplier between two requesters, building a
// 32x32 product from serial partial products accumulated into a 64-bit sum.
module workers_cpu_0_mul_sequencer #(
    parameter bit FULL_PRODUCT = 1'b1
) (
    input  logic clk,
    input  logic reset,
    workers_cpu_0_mul_sequencer_if.slave bus
);

    localparam logic [1:0] LAST_K = FULL_PRODUCT ? 2'd3 : 2'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic        rr_ptr;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_id;
    logic [1:0]  k;
    logic [63:0] acc;
    logic [31:0] mul_q;
    logic [1:0]  mul_k;
    logic        mul_pending;
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [31:0] rsp_lo_q;
    logic [31:0] rsp_hi_q;

    logic        grant0;
    logic        grant1;
    logic        accept;
    logic [15:0] mul_x;
    logic [15:0] mul_y;
    logic [63:0] pp_shifted;
    logic [63:0] acc_sum;

    // On contention the round-robin pointer picks; a lone requester always wins.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_ptr);
        grant1 = bus.req1_valid & (~bus.req0_valid | rr_ptr);
        accept = (state == IDLE) & (grant0 | grant1);
    end

    assign bus.req0_ready = (state == IDLE) & grant0 & ~reset;
    assign bus.req1_ready = (state == IDLE) & grant1 & ~reset;
    assign bus.busy       = (state != IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_lo     = rsp_lo_q;
    assign bus.rsp_hi     = rsp_hi_q;

    // k[1] selects the high half of a, k[0] the high half of b; the registered
    // product is weighted by the k it was issued with.
    always_comb begin
        mul_x      = k[1] ? op_a[31:16] : op_a[15:0];
        mul_y      = k[0] ? op_b[31:16] : op_b[15:0];
        pp_shifted = {32'd0, mul_q};
        case (mul_k)
            2'd0:       pp_shifted = {32'd0, mul_q};
            2'd1, 2'd2: pp_shifted = {16'd0, mul_q, 16'd0};
            default:    pp_shifted = {mul_q, 32'd0};
        endcase
        acc_sum = mul_pending ? (acc + pp_shifted) : acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   if (bus.flush) next_state = IDLE;
                     else if (k == LAST_K) next_state = DRAIN;
            DRAIN:   next_state = bus.flush ? IDLE : DONE;
            DONE:    if (bus.flush | bus.rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, partial-product issue, accumulation and response register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= 1'b0;
            k           <= '0;
            acc         <= '0;
            mul_q       <= '0;
            mul_k       <= '0;
            mul_pending <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_lo_q    <= '0;
            rsp_hi_q    <= '0;
        end else begin
            mul_pending <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= grant0 ? bus.req0_a : bus.req1_a;
                        op_b   <= grant0 ? bus.req0_b : bus.req1_b;
                        op_id  <= grant1;
                        rr_ptr <= ~grant1;
                        acc    <= '0;
                        k      <= '0;
                    end
                end
                ISSUE: begin
                    if (bus.flush) begin
                        acc <= '0;
                    end else begin
                        mul_q       <= 32'(mul_x) * 32'(mul_y);
                        mul_k       <= k;
                        mul_pending <= 1'b1;
                        k           <= k + 2'd1;
                        acc         <= acc_sum;
                    end
                end
                DRAIN: begin
                    if (bus.flush) begin
                        acc <= '0;
                    end else begin
                        acc         <= acc_sum;
                        rsp_lo_q    <= acc_sum[31:0];
                        rsp_hi_q    <= FULL_PRODUCT ? acc_sum[63:32] : 32'd0;
                        rsp_id_q    <= op_id;
                        rsp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.flush) begin
                        acc         <= '0;
                        rsp_valid_q <= 1'b0;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_workers_cpu_0_mul_sequencer.sv
// Randomized scoreboard bench for the shared multiplier sequencer, plus directed
// reset-in-flight and truncated-product (FULL_PRODUCT=0) sequences.
module tb_workers_cpu_0_mul_sequencer;

    typedef struct {
        logic        id;
        logic [63:0] prod;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   model_rr = 1'b0;
    int   stall = 0;
    exp_t sb[$];

    workers_cpu_0_mul_sequencer_if bus ();
    workers_cpu_0_mul_sequencer_if bus_lo ();

    workers_cpu_0_mul_sequencer #(.FULL_PRODUCT(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
    workers_cpu_0_mul_sequencer #(.FULL_PRODUCT(1'b0)) dut_lo (.clk(clk), .reset(reset), .bus(bus_lo));

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            2:       return {16'hFFFF, 16'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops the oldest expectation on each response handshake and
    // checks latency on the rising edge of rsp_valid and stability while stalled.
    logic        prev_valid = 1'b0;
    logic        hold = 1'b0;
    logic        held_id = 1'b0;
    logic [63:0] held_data = '0;
    always @(negedge clk) begin
        if (!reset) begin
            if (hold) begin
                checkOutput("hold_data", {bus.rsp_hi, bus.rsp_lo}, held_data);
                checkOutput("hold_status",
                            {59'd0, bus.rsp_valid, bus.rsp_id, bus.busy, bus.req0_ready, bus.req1_ready},
                            {59'd0, 1'b1, held_id, 1'b1, 1'b0, 1'b0});
            end
            if (bus.rsp_valid && !prev_valid && !bus.flush) begin
                checkOutput("rsp_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) checkOutput("latency", 64'(cyc - sb[0].acc_cyc), 64'd6);
            end
            if (bus.rsp_valid && bus.rsp_ready && !bus.flush && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                checkOutput("rsp_product", {bus.rsp_hi, bus.rsp_lo}, e.prod);
            end
            hold      = bus.rsp_valid && !bus.rsp_ready && !bus.flush;
            held_id   = bus.rsp_id;
            held_data = {bus.rsp_hi, bus.rsp_lo};
            prev_valid = bus.rsp_valid;
        end else begin
            hold       = 1'b0;
            prev_valid = 1'b0;
        end
    end

    // One cycle of stimulus: observe accepts/flush just before the edge, then
    // drive fresh values just after it.
    task automatic applyStimulus(input bit allow_new);
        bit a0, a1, win;
        exp_t e;
        @(negedge clk);
        a0 = bus.req0_valid & bus.req0_ready;
        a1 = bus.req1_valid & bus.req1_ready;
        if (bus.busy) checkOutput("ready_while_busy", 64'(bus.req0_ready | bus.req1_ready), 64'd0);
        if (a0 | a1) begin
            checkOutput("single_grant", 64'(a0 & a1), 64'd0);
            win = (bus.req0_valid && bus.req1_valid) ? model_rr : bus.req1_valid;
            checkOutput("arb_winner", 64'(a1), 64'(win));
            e.id      = a1;
            e.prod    = a1 ? (64'(bus.req1_a) * 64'(bus.req1_b)) : (64'(bus.req0_a) * 64'(bus.req0_b));
            e.acc_cyc = cyc;
            sb.push_back(e);
            model_rr = ~a1;
        end
        if (bus.flush && bus.busy && sb.size() > 0) void'(sb.pop_back());
        @(posedge clk);
        #1;
        if (a0) bus.req0_valid = 1'b0;
        if (a1) bus.req1_valid = 1'b0;
        if (allow_new && !bus.req0_valid && $urandom_range(0, 99) < 60) begin
            bus.req0_a = pick_operand();
            bus.req0_b = pick_operand();
            bus.req0_valid = 1'b1;
        end
        if (allow_new && !bus.req1_valid && $urandom_range(0, 99) < 60) begin
            bus.req1_a = pick_operand();
            bus.req1_b = pick_operand();
            bus.req1_valid = 1'b1;
        end
        bus.flush = allow_new && ($urandom_range(0, 99) < 4);
        if (stall > 0) stall--;
        else if (allow_new && $urandom_range(0, 99) < 4) stall = 12;
        bus.rsp_ready = allow_new ? (stall == 0 && $urandom_range(0, 99) < 65) : 1'b1;
    endtask

    task automatic drainAll();
        for (int i = 0; i < 200; i++) begin
            if (!bus.req0_valid && !bus.req1_valid && sb.size() == 0 && !bus.busy) break;
            applyStimulus(1'b0);
        end
        checkOutput("drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic runLo(input logic [31:0] a, input logic [31:0] b);
        bit got;
        int n;
        logic [63:0] full;
        full = 64'(a) * 64'(b);
        bus_lo.req0_a = a;
        bus_lo.req0_b = b;
        bus_lo.req0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_lo.req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("lo_accept", 64'(got), 64'd1);
        @(posedge clk);
        #1 bus_lo.req0_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus_lo.rsp_valid) begin
                n = i;
                break;
            end
        end
        checkOutput("lo_latency", 64'(n), 64'd4);
        checkOutput("lo_rsp_lo", 64'(bus_lo.rsp_lo), 64'(full[31:0]));
        checkOutput("lo_rsp_hi", 64'(bus_lo.rsp_hi), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.flush = 1'b0;  bus.rsp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b1; bus.req1_a = '0; bus.req1_b = '0;
        bus_lo.flush = 1'b0; bus_lo.rsp_ready = 1'b1;
        bus_lo.req0_valid = 1'b0; bus_lo.req0_a = '0; bus_lo.req0_b = '0;
        bus_lo.req1_valid = 1'b0; bus_lo.req1_a = '0; bus_lo.req1_b = '0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        checkOutput("reset_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
        checkOutput("reset_status", 64'({bus.rsp_valid, bus.rsp_id, bus.busy}), 64'd0);
        bus.req1_valid = 1'b0;
        bus.req0_a = 32'h0001_0003;
        bus.req0_b = 32'h0002_0005;
        bus.rsp_ready = 1'b1;
        reset = 1'b0;

        $display("[TB] random phase");
        for (int i = 0; i < 2500; i++) applyStimulus(1'b1);
        drainAll();

        $display("[TB] reset while in DRAIN");
        bus.req0_a = 32'hFFFF_FFFF;
        bus.req0_b = 32'hFFFF_FFFF;
        bus.req0_valid = 1'b1;
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("busy_in_drain", 64'(bus.busy), 64'd1);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        reset = 1'b1;
        #1;
        checkOutput("midop_reset_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
        checkOutput("midop_reset_status",
                    64'({bus.rsp_valid, bus.rsp_id, bus.busy, bus.req0_ready, bus.req1_ready}), 64'd0);
        #2 reset = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        model_rr = 1'b0;
        repeat (8) @(posedge clk);
        #1 checkOutput("no_rsp_after_reset", 64'({bus.rsp_valid, bus.busy}), 64'd0);

        for (int i = 0; i < 300; i++) applyStimulus(1'b1);
        drainAll();

        $display("[TB] truncated-product build");
        runLo(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runLo(32'h0001_0003, 32'h0002_0005);
        for (int i = 0; i < 4; i++) runLo(pick_operand(), pick_operand());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
